// File: rtl/bit_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bit_scan_pkg : shared state encoding, defaults and helpers for bit scan  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package bit_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int BS_WIDTH = 32;
  localparam int BS_CHUNK = 8;

  // Index width that stays legal (>= 1 bit) when the range has one entry.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_prio_enc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | chunk_prio_enc : lowest/highest set-bit encoder for one chunk            |
// | Rev 1.0  (cnt output present with BIT_SCAN_POPCOUNT_EN)                  |
// +--------------------------------------------------------------------------+
module chunk_prio_enc
  import bit_scan_pkg::*;
#(
  parameter  int CHUNK = BS_CHUNK,
  localparam int LOC_W = clog2_min1(CHUNK)
) (
  input  logic [CHUNK-1:0]           chunk,
  output logic                       any,
  output logic [LOC_W-1:0]           lo_idx,
  output logic [LOC_W-1:0]           hi_idx
`ifdef BIT_SCAN_POPCOUNT_EN
  ,
  output logic [$clog2(CHUNK+1)-1:0] cnt
`endif
);

  assign any = |chunk;

  // Descending sweep leaves the lowest set index; ascending leaves the highest.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) lo_idx = LOC_W'(i);
    end
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) hi_idx = LOC_W'(i);
    end
  end

`ifdef BIT_SCAN_POPCOUNT_EN
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + $bits(cnt)'(chunk[i]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/bit_scan_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bit_scan_unit : multi-cycle first/last set-bit scanner, CHUNK bits/cycle |
// | Rev 1.0  (optional popcount output: BIT_SCAN_POPCOUNT_EN)                |
// +--------------------------------------------------------------------------+
module bit_scan_unit
  import bit_scan_pkg::*;
#(
  parameter  int WIDTH = BS_WIDTH,
  parameter  int CHUNK = BS_CHUNK,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           operand,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [POS_W-1:0]           first_pos,
  output logic [POS_W-1:0]           last_pos,
  output logic                       zero
`ifdef BIT_SCAN_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcount
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = clog2_min1(NCHUNK);
  localparam int LOC_W  = clog2_min1(CHUNK);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   op_q;
  logic               found;
  logic               accept;
  logic               last_chunk;
  logic [POS_W-1:0]   base;
  logic [WIDTH-1:0]   op_shifted;
  logic [CHUNK-1:0]   cur_chunk;
  logic               chunk_any;
  logic [LOC_W-1:0]   lo_idx;
  logic [LOC_W-1:0]   hi_idx;
`ifdef BIT_SCAN_POPCOUNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [$clog2(CHUNK+1)-1:0] chunk_cnt;
`endif

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
  assign base       = POS_W'(idx) * POS_W'(CHUNK);
  assign op_shifted = op_q >> base;
  assign cur_chunk  = op_shifted[CHUNK-1:0];

  chunk_prio_enc #(
    .CHUNK (CHUNK)
  ) u_enc (
    .chunk  (cur_chunk),
    .any    (chunk_any),
    .lo_idx (lo_idx),
    .hi_idx (hi_idx)
`ifdef BIT_SCAN_POPCOUNT_EN
    ,
    .cnt    (chunk_cnt)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)     state_nxt = S_SCAN;
      S_SCAN:  if (last_chunk) state_nxt = S_DONE;
      S_DONE:  if (out_ready)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Chunks are visited in ascending order, so last_pos is simply overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      op_q      <= '0;
      first_pos <= '0;
      last_pos  <= '0;
      zero      <= 1'b1;
      found     <= 1'b0;
`ifdef BIT_SCAN_POPCOUNT_EN
      popcount  <= '0;
`endif
    end else if (accept) begin
      idx       <= '0;
      op_q      <= operand;
      first_pos <= '0;
      last_pos  <= '0;
      zero      <= 1'b1;
      found     <= 1'b0;
`ifdef BIT_SCAN_POPCOUNT_EN
      popcount  <= '0;
`endif
    end else if (state == S_SCAN) begin
      if (chunk_any) begin
        if (!found) begin
          first_pos <= base + POS_W'(lo_idx);
          found     <= 1'b1;
        end
        last_pos <= base + POS_W'(hi_idx);
        zero     <= 1'b0;
      end
`ifdef BIT_SCAN_POPCOUNT_EN
      popcount <= popcount + CNT_W'(chunk_cnt);
`endif
      if (!last_chunk) idx <= idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bit_scan_unit : vector table, random model compare, corner sequences  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bit_scan_unit;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] operand = '0;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  first_pos;
  logic [4:0]  last_pos;
  logic        zero;
`ifdef BIT_SCAN_POPCOUNT_EN
  logic [5:0]  popcount;
`endif

  bit_scan_unit #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .first_pos (first_pos),
    .last_pos  (last_pos),
    .zero      (zero)
`ifdef BIT_SCAN_POPCOUNT_EN
    ,
    .popcount  (popcount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    int          first;
    int          last;
    int          zr;
    int          pop;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference: plain bit walk over the whole operand.
  task automatic ref_model(input logic [31:0] v, output int f, output int l,
                           output int z, output int p);
    f = 0; l = 0; z = 1; p = 0;
    for (int b = 0; b < WIDTH; b++) begin
      if (v[b]) begin
        if (z == 1) f = b;
        l = b;
        z = 0;
        p++;
      end
    end
  endtask

  // Present an operand, return cycles from acceptance edge to out_valid.
  task automatic run_op(input logic [31:0] v, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    operand  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand  = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_release", out_valid, 0);
    check("in_ready_after_release", in_ready, 1);
  endtask

  task automatic check_result(input string tag, input int f, input int l,
                              input int z, input int p, input int lat);
    check({tag, "_latency"}, lat, NCHUNK);
    check({tag, "_first_pos"}, first_pos, f);
    check({tag, "_last_pos"}, last_pos, l);
    check({tag, "_zero"}, zero, z);
`ifdef BIT_SCAN_POPCOUNT_EN
    check({tag, "_popcount"}, popcount, p);
`else
    if (p < 0) $display("negative popcount %0d", p);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    int   f, l, z, p;
    logic [31:0] v;

    vecs[0] = '{32'h0000_0100,  8,  8, 0,  1};
    vecs[1] = '{32'h8000_0001,  0, 31, 0,  2};
    vecs[2] = '{32'h0001_0000, 16, 16, 0,  1};
    vecs[3] = '{32'h0000_0000,  0,  0, 1,  0};
    vecs[4] = '{32'hF0F0_0001,  0, 31, 0,  9};
    vecs[5] = '{32'hFFFF_FFFF,  0, 31, 0, 32};
    vecs[6] = '{32'h0000_00F0,  4,  7, 0,  4};

    #12;
    check("reset_first_pos", first_pos, 0);
    check("reset_last_pos", last_pos, 0);
    check("reset_zero", zero, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, lat);
      check_result($sformatf("vec%0d", i), vecs[i].first, vecs[i].last,
                   vecs[i].zr, vecs[i].pop, lat);
      release_result();
    end

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       v = $urandom;
        1:       v = 32'h1 << $urandom_range(31, 0);
        default: v = $urandom & $urandom & $urandom;
      endcase
      ref_model(v, f, l, z, p);
      run_op(v, lat);
      check_result($sformatf("rand%0d", i), f, l, z, p, lat);
      release_result();
    end

    // Backpressure: result held, new operands refused while in DONE.
    run_op(32'h0000_0C00, lat);
    check_result("bp", 10, 11, 0, 2, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      operand  = 32'h0000_0001;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_first_pos", first_pos, 10);
      check("bp_last_pos", last_pos, 11);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_released_in_ready", in_ready, 1);
    check("bp_released_out_valid", out_valid, 0);
    check("bp_retained_first_pos", first_pos, 10);
    @(posedge clk);
    #1;
    check("bp_idle_stays", in_ready, 1);
    check("bp_retained_last_pos", last_pos, 11);

    // Asynchronous reset while scanning chunk index 2.
    @(negedge clk);
    in_valid = 1'b1;
    operand  = 32'h0000_0300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("midscan_first_pos_partial", first_pos, 8);
    check("midscan_in_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_first_pos", first_pos, 0);
    check("rst_zero", zero, 1);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(32'h0000_00F0, lat);
    check_result("post_rst", 4, 7, 0, 4, lat);
    release_result();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_scan_unit.md
Name: bit_scan_unit

Overview:
Parametrised multi-cycle bit scanner for the ALU datapath. Accepts a WIDTH-bit operand over a valid/ready handshake and scans it CHUNK bits per cycle. Reports the lowest and highest set-bit positions and an all-zero flag over a registered result handshake. Replaces the 8-bit combinational first/last-set-bit finder for wide operands, where a single-cycle priority encoder breaks timing.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2 and a multiple of CHUNK
CHUNK, 8, bits examined per SCAN cycle; must be >= 1 and divide WIDTH
(derived) NCHUNK = WIDTH/CHUNK; POS_W = $clog2(WIDTH); CNT_W = $clog2(WIDTH+1); IDX_W = max(1,$clog2(NCHUNK))

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  unit can accept operand
operand  input  WIDTH  value to scan
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
first_pos  output  POS_W  index of lowest set bit (0 if operand zero)
last_pos  output  POS_W  index of highest set bit (0 if operand zero)
zero  output  1  operand had no set bits
popcount  output  CNT_W  number of set bits (present only with BIT_SCAN_POPCOUNT_EN)

Behaviour:
- Reset is asynchronous, active-low: state=IDLE, chunk index=0, operand register=0; first_pos=0, last_pos=0, zero=1, popcount=0, out_valid=0. in_ready=1 while in IDLE.
- FSM: IDLE -> SCAN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch operand, clear idx, first_pos/last_pos/popcount, set zero=1, found=0, then go to SCAN.
- SCAN: in_ready=0, out_valid=0. Each cycle, take chunk c = operand[idx*CHUNK +: CHUNK]. If c != 0:
  - when found=0, set first_pos = idx*CHUNK + lowest set index in c, and found=1;
  - set last_pos = idx*CHUNK + highest set index in c, overwriting any previous value (chunks are scanned ascending);
  - set zero=0.
- SCAN, idx rule: when idx == NCHUNK-1, go to DONE; otherwise idx++.
- DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready=1, then go to IDLE (out_valid drops next cycle).
- Latency: out_valid rises exactly NCHUNK cycles after the acceptance edge. Throughput is one operation per NCHUNK+2 cycles minimum; no overlap of operations.
- in_valid outside IDLE is ignored; the operand is not sampled. The operand may change after acceptance without effect.
- Zero operand: first_pos=0, last_pos=0, zero=1.
- Single set bit: first_pos == last_pos.
- NCHUNK=1: one SCAN cycle.
- Outputs retain their last result after returning to IDLE until the next acceptance clears them.
- reset_n asserted mid-SCAN or in DONE: the operation is aborted immediately and asynchronously. Outputs return to reset values and no result is produced.
- Position arithmetic is unsigned. idx*CHUNK + local index never exceeds WIDTH-1.

Optional Feature:
BIT_SCAN_POPCOUNT_EN
- Defined: popcount port exists. Each SCAN cycle adds the popcount of c to a CNT_W-bit accumulator; the value is valid with out_valid.
- Undefined: popcount port and accumulator are absent. All other behaviour is identical.

Decomposition:
- Package bit_scan_pkg holds:
  - state enum {S_IDLE, S_SCAN, S_DONE};
  - default constants BS_WIDTH=32, BS_CHUNK=8;
  - helper function clog2_min1.
- One combinational sub-module, chunk_prio_enc #(CHUNK): input chunk, outputs any, lo_idx, hi_idx ($clog2(CHUNK) bits, min 1), and cnt when the feature is enabled. Instantiated once in bit_scan_unit.

Test Plan:
All cases use WIDTH=32, CHUNK=8.
- Accept operand 0x0000_0100 -> 4 cycles later out_valid=1, first_pos=8, last_pos=8, zero=0.
- Accept operand 0x8000_0001 -> first_pos=0, last_pos=31, zero=0. Then operand 0x0001_0000 -> first_pos=16, last_pos=16.
- Accept operand 0x0000_0000 -> first_pos=0, last_pos=0, zero=1, out_valid after 4 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with a new operand -> outputs stable, in_ready=0, new operand not taken. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-SCAN (idx=2) -> out_valid=0, in_ready=1, first_pos=0 immediately without a clock. A following operand 0x0000_00F0 gives first_pos=4, last_pos=7.
- With BIT_SCAN_POPCOUNT_EN: operand 0xF0F0_0001 -> popcount=9, first_pos=0, last_pos=31. Operand 0xFFFF_FFFF -> popcount=32.
